// File: rtl/lsu_ctrl_pkg.sv
// rtl/lsu_ctrl_pkg.sv - shared widths, encodings and helpers for the load/store unit
package lsu_ctrl_pkg;

  localparam int XLEN          = 32;
  localparam int AXI_DATA_BITS = 32;
  localparam int STRB_BITS     = AXI_DATA_BITS / 8;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } lsu_state_e;

  // Unsigned sizes exist only for loads.
  function automatic logic funct3_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      3'b000, 3'b001, 3'b010: funct3_legal = 1'b1;
      3'b100, 3'b101:         funct3_legal = ~is_store;
      default:                funct3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - word-aligned data-memory request/response bus
interface lsu_ctrl_if;
  import lsu_ctrl_pkg::*;

  logic                     req;
  logic                     we;
  logic [XLEN-1:0]          addr;
  logic [STRB_BITS-1:0]     wstrb;
  logic [AXI_DATA_BITS-1:0] wdata;
  logic                     gnt;
  logic                     rvalid;
  logic [AXI_DATA_BITS-1:0] rdata;
  logic                     err;

  modport master (output req, we, addr, wstrb, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, wstrb, wdata, output gnt, rvalid, rdata, err);

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte strobes, store lane replication, load extract/extend, misalign check
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [2:0]               st_funct3_i,
  input  logic [1:0]               st_off_i,
  input  logic [XLEN-1:0]          wdata_i,
  output logic [STRB_BITS-1:0]     wstrb_o,
  output logic [AXI_DATA_BITS-1:0] wdata_o,
  output logic                     misalign_o,
  input  logic [2:0]               ld_funct3_i,
  input  logic [1:0]               ld_off_i,
  input  logic [AXI_DATA_BITS-1:0] rdata_i,
  output logic [XLEN-1:0]          load_data_o
);

  logic [AXI_DATA_BITS-1:0] shifted;

  always_comb begin
    wstrb_o    = '0;
    wdata_o    = wdata_i;
    misalign_o = 1'b0;
    case (lsu_size_e'(st_funct3_i))
      SZ_B, SZ_BU: begin
        wstrb_o = 4'b0001 << st_off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_H, SZ_HU: begin
        wstrb_o    = 4'b0011 << st_off_i;
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = st_off_i[0];
      end
      SZ_W: begin
        wstrb_o    = 4'b1111;
        misalign_o = |st_off_i;
      end
      default: ;
    endcase
  end

  // Word loads are always aligned, so the shifted word equals the raw word.
  assign shifted = rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    case (lsu_size_e'(ld_funct3_i))
      SZ_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      SZ_BU:   load_data_o = {24'h0, shifted[7:0]};
      SZ_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      SZ_HU:   load_data_o = {16'h0, shifted[15:0]};
      default: load_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit: MEM-stage request to data bus transaction with stall/fault
module lsu_ctrl
  import lsu_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ren_i,
  input  logic            wen_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic            fault_o,
  output logic [XLEN-1:0] load_data_o,
  lsu_ctrl_if.master      bus
);

  lsu_state_e               state_q, state_d;
  logic [XLEN-1:0]          addr_q;
  logic                     we_q;
  logic [2:0]               funct3_q;
  logic [STRB_BITS-1:0]     strb_q, strb_d;
  logic [AXI_DATA_BITS-1:0] wdata_q, wdata_d;
  logic [AXI_DATA_BITS-1:0] rdata_q;
  logic                     err_q;
  logic                     flushed_q;
  logic                     misalign;
  logic [XLEN-1:0]          load_ext;
  logic                     req_live, illegal, accept, reject, bus_req;

  lsu_align u_align (
    .st_funct3_i (funct3_i),
    .st_off_i    (addr_i[1:0]),
    .wdata_i     (wdata_i),
    .wstrb_o     (strb_d),
    .wdata_o     (wdata_d),
    .misalign_o  (misalign),
    .ld_funct3_i (funct3_q),
    .ld_off_i    (addr_q[1:0]),
    .rdata_i     (rdata_q),
    .load_data_o (load_ext)
  );

  // rst_n gates the comb decode so stall/fault read 0 while reset is held.
  assign req_live = rst_n & (ren_i | wen_i) & ~flush_i & (state_q == ST_IDLE);
  assign illegal  = (ren_i & wen_i) | ~funct3_legal(funct3_i, wen_i);
  assign accept   = req_live & ~illegal & ~misalign;
  assign reject   = req_live & (illegal | misalign);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      funct3_q  <= '0;
      strb_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q    <= addr_i;
        we_q      <= wen_i;
        funct3_q  <= funct3_i;
        strb_q    <= wen_i ? strb_d : '0;
        wdata_q   <= wen_i ? wdata_d : '0;
        flushed_q <= 1'b0;
      end
      // A flush arriving once the bus owns the access only silences the result.
      if (state_q == ST_REQ && bus.gnt && flush_i) flushed_q <= 1'b1;
      if (state_q == ST_RESP) begin
        if (flush_i) flushed_q <= 1'b1;
        if (bus.rvalid) begin
          rdata_q <= bus.rdata;
          err_q   <= bus.err;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_REQ;
      ST_REQ: begin
        if (bus.gnt)      state_d = ST_RESP;
        else if (flush_i) state_d = ST_IDLE;
      end
      ST_RESP: if (bus.rvalid) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_o     = 1'b0;
    done_o      = 1'b0;
    fault_o     = 1'b0;
    load_data_o = '0;
    bus_req     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall_o = accept;
        fault_o = reject;
      end
      ST_REQ: begin
        stall_o = 1'b1;
        bus_req = 1'b1;
      end
      ST_RESP: stall_o = 1'b1;
      ST_DONE: begin
        done_o      = ~flushed_q;
        fault_o     = err_q & ~flushed_q;
        load_data_o = err_q ? '0 : load_ext;
      end
      default: ;
    endcase
  end

  assign bus.req   = bus_req;
  assign bus.we    = we_q;
  assign bus.addr  = {addr_q[XLEN-1:2], 2'b00};
  assign bus.wstrb = strb_q;
  assign bus.wdata = wdata_q;

endmodule
